multicycle_controller: RTL and testbench

Finite-state control unit that sequences the shared CPU datapath (one memory port, one ALU, register file) over several cycles per instruction, replacing single-cycle decode. It fetches through a variable-latency memory with a ready handshake, decodes op/func, and drives every datapath select and write strobe. It also retires an instruction count and traps illegal encodings into a halt state.

---
 rtl/cpu_ctrl_pkg.sv | 53 +++++
 rtl/alu_decoder.sv | 45 ++++
 rtl/multicycle_controller.sv | 168 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit: FSM states, ALU
// operations, opcode/func values and datapath select codes.
package cpu_ctrl_pkg;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_EXEC_I    = 4'd10;
  localparam logic [3:0] S_I_WB      = 4'd11;
  localparam logic [3:0] S_HALT      = 4'd12;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] SRCB_BUSB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation and immediate-extension decode for the
// multicycle controller; func_valid flags unsupported R-type functions.
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic [3:0] state,
  output logic [2:0] ALUctr,
  output logic       ExtOp,
  output logic       func_valid
);

  logic [2:0] r_ctr;

  always_comb begin
    func_valid = 1'b1;
    r_ctr      = ALU_ADD;
    case (func)
      FN_ADD:  r_ctr = ALU_ADD;
      FN_SUB:  r_ctr = ALU_SUB;
      FN_AND:  r_ctr = ALU_AND;
      FN_OR:   r_ctr = ALU_OR;
      FN_SLT:  r_ctr = ALU_SLT;
      default: func_valid = 1'b0;
    endcase
  end

  always_comb begin
    ALUctr = ALU_ADD;
    ExtOp  = 1'b0;
    case (state)
      S_DECODE, S_MEM_ADDR: ExtOp = 1'b1;
      S_EXEC_R:             ALUctr = r_ctr;
      S_BRANCH:             ALUctr = ALU_SUB;
      // I_WB keeps the EXEC_I settings so ALUOut is not disturbed
      S_EXEC_I, S_I_WB: begin
        if (op == OP_ORI) ALUctr = ALU_OR;
        else              ExtOp  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute over a shared
// datapath, counts retired instructions and halts on illegal ops or stalls.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWr,
  output logic        IRWr,
  output logic        MemRd,
  output logic        MemWr,
  output logic        IorD,
  output logic        RegWr,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUctr,
  output logic [1:0]  PCSrc,
  output logic        ExtOp,
  output logic        retire,
  output logic [31:0] inst_count,
  output logic        illegal_op,
  output logic        mem_timeout,
  output logic [3:0]  state
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

  logic [3:0]    next_state;
  logic [CW-1:0] stall_cnt;
  logic          func_valid, illegal_hit, stall, timeout_hit, retire_raw;
  logic          pc_wr, ir_wr, mem_rd, mem_wr, reg_wr;

  alu_decoder u_alu_decoder (
    .op         (op),
    .func       (func),
    .state      (state),
    .ALUctr     (ALUctr),
    .ExtOp      (ExtOp),
    .func_valid (func_valid)
  );

  // Memory handshake: MemRd/MemWr and IorD hold steady in a memory state
  // until the cycle mem_ready=1 completes the access; mem_ready is ignored
  // in every other state.
  assign stall       = is_mem_state(state) && !mem_ready;
  assign timeout_hit = stall && (stall_cnt == WAIT_LAST);

  always_comb begin
    next_state  = state;
    illegal_hit = 1'b0;
    case (state)
      S_FETCH: if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:       next_state = S_EXEC_R;
          OP_LW, OP_SW:   next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J:           next_state = S_JUMP;
          OP_ADDI, OP_ORI: next_state = S_EXEC_I;
          default: begin
            next_state  = S_HALT;
            illegal_hit = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        if (op == OP_LW)      next_state = S_MEM_READ;
        else if (op == OP_SW) next_state = S_MEM_WRITE;
        else begin
          next_state  = S_HALT;
          illegal_hit = 1'b1;
        end
      end
      S_MEM_READ:  if (mem_ready) next_state = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) next_state = S_FETCH;
      S_EXEC_R: begin
        if (func_valid) next_state = S_R_WB;
        else begin
          next_state  = S_HALT;
          illegal_hit = 1'b1;
        end
      end
      S_EXEC_I: next_state = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default: begin
        next_state  = S_HALT;
        illegal_hit = 1'b1;
      end
    endcase
    if (timeout_hit) next_state = S_HALT;
  end

  assign retire_raw = (next_state == S_FETCH) && (state != S_FETCH);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= S_FETCH;
      inst_count  <= 32'd0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state <= next_state;
      if (retire_raw)  inst_count  <= inst_count + 32'd1;
      if (illegal_hit) illegal_op  <= 1'b1;
      if (timeout_hit) mem_timeout <= 1'b1;
      stall_cnt <= (stall && !timeout_hit) ? stall_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    reg_wr   = 1'b0;
    IorD     = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_BUSB;
    PCSrc    = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        mem_rd  = 1'b1;
        ALUSrcB = SRCB_FOUR;
        pc_wr   = mem_ready;
        ir_wr   = mem_ready;
      end
      S_DECODE:   ALUSrcB = SRCB_IMM_SH2;
      S_MEM_ADDR: begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
      S_MEM_READ: begin mem_rd = 1'b1; IorD = 1'b1; end
      S_MEM_WB:   begin reg_wr = 1'b1; MemtoReg = 1'b1; end
      S_MEM_WRITE: begin mem_wr = 1'b1; IorD = 1'b1; end
      S_EXEC_R:   ALUSrcA = 1'b1;
      S_R_WB:     begin reg_wr = 1'b1; RegDst = 1'b1; end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        PCSrc   = PCSRC_ALUOUT;
        pc_wr   = (op == OP_BNE) ? ~Zero : Zero;
      end
      S_JUMP:   begin PCSrc = PCSRC_JUMP; pc_wr = 1'b1; end
      S_EXEC_I: begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
      S_I_WB:   reg_wr = 1'b1;
      default: ;
    endcase
  end

  // Strobes drop the instant Reset rises so an abandoned instruction never
  // leaves a partial write behind.
  assign PCWr   = pc_wr  & ~Reset;
  assign IRWr   = ir_wr  & ~Reset;
  assign MemRd  = mem_rd & ~Reset;
  assign MemWr  = mem_wr & ~Reset;
  assign RegWr  = reg_wr & ~Reset;
  assign retire = retire_raw & ~Reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle against hand-computed state and control vectors.
module tb_multicycle_controller;

  logic        Clock = 1'b0;
  logic        Reset, Zero, mem_ready;
  logic [5:0]  op, func;
  logic        PCWr, IRWr, MemRd, MemWr, IorD, RegWr, RegDst, MemtoReg, ALUSrcA, ExtOp;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALUctr;
  logic        retire, illegal_op, mem_timeout;
  logic [31:0] inst_count;
  logic [3:0]  state;
  logic [16:0] ctl;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_count = 32'd0;

  // ctl = {PCWr,IRWr,MemRd,MemWr,IorD,RegWr,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUctr,PCSrc,ExtOp}
  assign ctl = {PCWr, IRWr, MemRd, MemWr, IorD, RegWr, RegDst, MemtoReg, ALUSrcA,
                ALUSrcB, ALUctr, PCSrc, ExtOp};

  localparam logic [16:0] C_FETCH_GO   = 17'b1_1_1_0_0_0_0_0_0_01_000_00_0;
  localparam logic [16:0] C_FETCH_WAIT = 17'b0_0_1_0_0_0_0_0_0_01_000_00_0;
  localparam logic [16:0] C_FETCH_RST  = 17'b0_0_0_0_0_0_0_0_0_01_000_00_0;
  localparam logic [16:0] C_DECODE     = 17'b0_0_0_0_0_0_0_0_0_11_000_00_1;
  localparam logic [16:0] C_EXEC_ADD   = 17'b0_0_0_0_0_0_0_0_1_00_000_00_0;
  localparam logic [16:0] C_R_WB       = 17'b0_0_0_0_0_1_1_0_0_00_000_00_0;
  localparam logic [16:0] C_MEM_ADDR   = 17'b0_0_0_0_0_0_0_0_1_10_000_00_1;
  localparam logic [16:0] C_MEM_READ   = 17'b0_0_1_0_1_0_0_0_0_00_000_00_0;
  localparam logic [16:0] C_MEM_WB     = 17'b0_0_0_0_0_1_0_1_0_00_000_00_0;
  localparam logic [16:0] C_MEM_WRITE  = 17'b0_0_0_1_1_0_0_0_0_00_000_00_0;
  localparam logic [16:0] C_JUMP       = 17'b1_0_0_0_0_0_0_0_0_00_000_10_0;
  localparam logic [16:0] C_ADDI_EX    = 17'b0_0_0_0_0_0_0_0_1_10_000_00_1;
  localparam logic [16:0] C_ADDI_WB    = 17'b0_0_0_0_0_1_0_0_0_00_000_00_1;
  localparam logic [16:0] C_ORI_EX     = 17'b0_0_0_0_0_0_0_0_1_10_011_00_0;
  localparam logic [16:0] C_ORI_WB     = 17'b0_0_0_0_0_1_0_0_0_00_011_00_0;
  localparam logic [15:0] C_BRANCH_LO  = 16'b0_0_0_0_0_0_0_1_00_001_01_0;

  multicycle_controller #(.MEM_WAIT_MAX(4)) dut (
    .Clock(Clock), .Reset(Reset), .op(op), .func(func), .Zero(Zero),
    .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .MemRd(MemRd), .MemWr(MemWr),
    .IorD(IorD), .RegWr(RegWr), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUctr(ALUctr), .PCSrc(PCSrc),
    .ExtOp(ExtOp), .retire(retire), .inst_count(inst_count),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic test_reset();
    Reset = 1'b1; op = 6'd0; func = 6'd0; Zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (inst_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", inst_count); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", illegal_op); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout); end
    total++; if (ctl !== C_FETCH_RST) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_FETCH_RST); end
    total++; if (retire !== 1'b0) begin bad++; $display("FAIL reset_retire got=%b exp=0", retire); end
    #2 Reset = 1'b0;
    #1;
    total++; if (ctl !== C_FETCH_GO) begin bad++; $display("FAIL release_ctl got=%b exp=%b", ctl, C_FETCH_GO); end
  endtask

  task automatic test_add();
    logic [3:0]  est [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    logic [16:0] ectl [4] = '{C_FETCH_GO, C_DECODE, C_EXEC_ADD, C_R_WB};
    op = 6'b000000; func = 6'b100000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      total++; if (state !== est[i]) begin bad++; $display("FAIL add_state[%0d] got=%0d exp=%0d", i, state, est[i]); end
      total++; if (ctl !== ectl[i]) begin bad++; $display("FAIL add_ctl[%0d] got=%b exp=%b", i, ctl, ectl[i]); end
      total++; if (retire !== (i == 3)) begin bad++; $display("FAIL add_retire[%0d] got=%b exp=%b", i, retire, (i == 3)); end
      tick();
    end
    exp_count++;
    total++; if (inst_count !== exp_count) begin bad++; $display("FAIL add_count got=%0d exp=%0d", inst_count, exp_count); end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL add_back_fetch got=%0d exp=0", state); end
  endtask

  task automatic test_r_funcs();
    logic [5:0] fn [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] ac [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    logic [3:0] est [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    op = 6'b000000;
    for (int k = 0; k < 4; k++) begin
      func = fn[k];
      for (int i = 0; i < 4; i++) begin
        mem_ready = 1'b1; #1;
        total++; if (state !== est[i]) begin bad++; $display("FAIL rfn%0d_state[%0d] got=%0d exp=%0d", k, i, state, est[i]); end
        if (i == 2) begin
          total++; if (ALUctr !== ac[k]) begin bad++; $display("FAIL rfn%0d_aluctr got=%b exp=%b", k, ALUctr, ac[k]); end
        end
        tick();
      end
      exp_count++;
    end
    total++; if (inst_count !== exp_count) begin bad++; $display("FAIL rfn_count got=%0d exp=%0d", inst_count, exp_count); end
  endtask

  task automatic test_lw_stall();
    logic [3:0]  est [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    logic        rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [16:0] ectl [8] = '{C_FETCH_GO, C_DECODE, C_MEM_ADDR, C_MEM_READ,
                              C_MEM_READ, C_MEM_READ, C_MEM_READ, C_MEM_WB};
    op = 6'b100011; func = 6'd0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i]; #1;
      total++; if (state !== est[i]) begin bad++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, est[i]); end
      total++; if (ctl !== ectl[i]) begin bad++; $display("FAIL lw_ctl[%0d] got=%b exp=%b", i, ctl, ectl[i]); end
      total++; if (retire !== (i == 7)) begin bad++; $display("FAIL lw_retire[%0d] got=%b exp=%b", i, retire, (i == 7)); end
      tick();
    end
    exp_count++;
    total++; if (inst_count !== exp_count) begin bad++; $display("FAIL lw_count got=%0d exp=%0d", inst_count, exp_count); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL lw_no_timeout got=%b exp=0", mem_timeout); end
  endtask

  task automatic test_sw();
    logic [3:0]  est [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    logic [16:0] ectl [4] = '{C_FETCH_GO, C_DECODE, C_MEM_ADDR, C_MEM_WRITE};
    op = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      total++; if (state !== est[i]) begin bad++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state, est[i]); end
      total++; if (ctl !== ectl[i]) begin bad++; $display("FAIL sw_ctl[%0d] got=%b exp=%b", i, ctl, ectl[i]); end
      total++; if (retire !== (i == 3)) begin bad++; $display("FAIL sw_retire[%0d] got=%b exp=%b", i, retire, (i == 3)); end
      tick();
    end
    exp_count++;
    total++; if (inst_count !== exp_count) begin bad++; $display("FAIL sw_count got=%0d exp=%0d", inst_count, exp_count); end
  endtask

  task automatic test_branch();
    logic [5:0]  bop [4] = '{6'b000100, 6'b000101, 6'b000101, 6'b000010};
    logic        bz  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  elast [4] = '{4'd8, 4'd8, 4'd8, 4'd9};
    logic [16:0] ectl [4] = '{{1'b1, C_BRANCH_LO}, {1'b0, C_BRANCH_LO}, {1'b1, C_BRANCH_LO}, C_JUMP};
    logic [3:0]  es;
    for (int k = 0; k < 4; k++) begin
      op = bop[k]; Zero = bz[k];
      for (int i = 0; i < 3; i++) begin
        mem_ready = 1'b1; #1;
        es = (i == 0) ? 4'd0 : (i == 1) ? 4'd1 : elast[k];
        total++; if (state !== es) begin bad++; $display("FAIL br%0d_state[%0d] got=%0d exp=%0d", k, i, state, es); end
        total++; if (retire !== (i == 2)) begin bad++; $display("FAIL br%0d_retire[%0d] got=%b exp=%b", k, i, retire, (i == 2)); end
        if (i == 2) begin
          total++; if (ctl !== ectl[k]) begin bad++; $display("FAIL br%0d_ctl got=%b exp=%b", k, ctl, ectl[k]); end
        end
        tick();
      end
      exp_count++;
    end
    Zero = 1'b0;
    total++; if (inst_count !== exp_count) begin bad++; $display("FAIL br_count got=%0d exp=%0d", inst_count, exp_count); end
  endtask

  task automatic test_imm();
    logic [5:0]  iop [2] = '{6'b001000, 6'b001101};
    logic [16:0] cex [2] = '{C_ADDI_EX, C_ORI_EX};
    logic [16:0] cwb [2] = '{C_ADDI_WB, C_ORI_WB};
    logic [3:0]  est [4] = '{4'd0, 4'd1, 4'd10, 4'd11};
    logic [16:0] ec;
    for (int k = 0; k < 2; k++) begin
      op = iop[k];
      for (int i = 0; i < 4; i++) begin
        mem_ready = 1'b1; #1;
        ec = (i == 0) ? C_FETCH_GO : (i == 1) ? C_DECODE : (i == 2) ? cex[k] : cwb[k];
        total++; if (state !== est[i]) begin bad++; $display("FAIL imm%0d_state[%0d] got=%0d exp=%0d", k, i, state, est[i]); end
        total++; if (ctl !== ec) begin bad++; $display("FAIL imm%0d_ctl[%0d] got=%b exp=%b", k, i, ctl, ec); end
        tick();
      end
      exp_count++;
    end
    total++; if (inst_count !== exp_count) begin bad++; $display("FAIL imm_count got=%0d exp=%0d", inst_count, exp_count); end
  endtask

  task automatic test_illegal();
    op = 6'b111111; func = 6'd0;
    mem_ready = 1'b1; #1; tick();
    #1;
    total++; if (state !== 4'd1) begin bad++; $display("FAIL ill_decode_state got=%0d exp=1", state); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL ill_early got=%b exp=0", illegal_op); end
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = i[0]; #1;
      total++; if (state !== 4'd12) begin bad++; $display("FAIL ill_state[%0d] got=%0d exp=12", i, state); end
      total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL ill_flag[%0d] got=%b exp=1", i, illegal_op); end
      total++; if (ctl !== 17'd0) begin bad++; $display("FAIL ill_ctl[%0d] got=%b exp=0", i, ctl); end
      total++; if (retire !== 1'b0) begin bad++; $display("FAIL ill_retire[%0d] got=%b exp=0", i, retire); end
      tick();
    end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL ill_timeout got=%b exp=0", mem_timeout); end
    total++; if (inst_count !== exp_count) begin bad++; $display("FAIL ill_count_hold got=%0d exp=%0d", inst_count, exp_count); end
    Reset = 1'b1; #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL ill_rst_state got=%0d exp=0", state); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL ill_rst_flag got=%b exp=0", illegal_op); end
    #3 Reset = 1'b0; #1;
    exp_count = 32'd0;
    // Unsupported R-type func halts from EXEC_R
    op = 6'b000000; func = 6'b111111;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      if (i == 3) begin
        total++; if (state !== 4'd12) begin bad++; $display("FAIL badfn_state got=%0d exp=12", state); end
        total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL badfn_flag got=%b exp=1", illegal_op); end
        total++; if (inst_count !== exp_count) begin bad++; $display("FAIL badfn_count got=%0d exp=%0d", inst_count, exp_count); end
      end
      tick();
    end
    Reset = 1'b1; #4 Reset = 1'b0; #1;
  endtask

  task automatic test_timeout();
    op = 6'b000000; func = 6'b100000; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (state !== 4'd0) begin bad++; $display("FAIL to_state[%0d] got=%0d exp=0", i, state); end
      total++; if (ctl !== C_FETCH_WAIT) begin bad++; $display("FAIL to_ctl[%0d] got=%b exp=%b", i, ctl, C_FETCH_WAIT); end
      total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL to_early[%0d] got=%b exp=0", i, mem_timeout); end
      tick();
    end
    #1;
    total++; if (state !== 4'd12) begin bad++; $display("FAIL to_halt got=%0d exp=12", state); end
    total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%b exp=1", mem_timeout); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL to_illegal got=%b exp=0", illegal_op); end
    total++; if (ctl !== 17'd0) begin bad++; $display("FAIL to_ctl_halt got=%b exp=0", ctl); end
    Reset = 1'b1; #1;
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL to_rst got=%b exp=0", mem_timeout); end
    #3 Reset = 1'b0; #1;
  endtask

  task automatic test_reset_mid();
    op = 6'b101011;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; #1; tick();
    end
    mem_ready = 1'b0; #1;
    total++; if (state !== 4'd5) begin bad++; $display("FAIL rm_state got=%0d exp=5", state); end
    total++; if (MemWr !== 1'b1) begin bad++; $display("FAIL rm_memwr got=%b exp=1", MemWr); end
    #2 Reset = 1'b1; #1;
    total++; if (MemWr !== 1'b0) begin bad++; $display("FAIL rm_memwr_drop got=%b exp=0", MemWr); end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL rm_async_state got=%0d exp=0", state); end
    #1 Reset = 1'b0; #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL rm_rel_state got=%0d exp=0", state); end
    total++; if (inst_count !== 32'd0) begin bad++; $display("FAIL rm_count got=%0d exp=0", inst_count); end
    tick();
    total++; if (ctl !== C_FETCH_WAIT) begin bad++; $display("FAIL rm_after_ctl got=%b exp=%b", ctl, C_FETCH_WAIT); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_r_funcs();
    test_lw_stall();
    test_sw();
    test_branch();
    test_imm();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
